// File: rtl/ppu_ri.sv
// CPU-facing PPU register file ($2000-$2007): scroll/control latches, status flags,
// NMI request, $2007 read buffer and the VRAM/palette access sequencer.
module ppu_ri (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [2:0] sel_in,
  input  logic       ncs_in,
  input  logic       r_nw_in,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  input  logic [13:0] vram_a_in,
  input  logic [7:0] vram_d_in,
  input  logic [5:0] pram_d_in,
  output logic [7:0] vram_d_out,
  output logic       vram_wr_out,
  output logic       pram_wr_out,
  input  logic       vblank_set_in,
  input  logic       vblank_clr_in,
  input  logic       spr_0_hit_in,
  input  logic       spr_overflow_in,
  output logic [2:0] fv_out,
  output logic [4:0] vt_out,
  output logic       v_out,
  output logic [2:0] fh_out,
  output logic [4:0] ht_out,
  output logic       h_out,
  output logic       s_out,
  output logic       spr_pt_sel_out,
  output logic       spr_h_out,
  output logic       inc_addr_out,
  output logic       inc_addr_amt_out,
  output logic       upd_cntrs_out,
  output logic       bg_en_out,
  output logic       spr_en_out,
  output logic       bg_ls_clip_out,
  output logic       spr_ls_clip_out,
  output logic       nmi_out
);

  typedef enum logic [1:0] {IDLE, XFER, INC} state_t;

  state_t     state_q, state_d;
  logic       q_ncs;
  logic       toggle_q;
  logic       vblank_q;
  logic       nmi_en_q;
  logic       rnw_q;
  logic [7:0] rd_buf_q;

  logic access, wr_acc, rd_acc, pal_range;

  // One action per falling chip-select edge, and only when no $2007 transfer is in flight.
  assign access    = ~ncs_in & q_ncs & (state_q == IDLE);
  assign wr_acc    = access & ~r_nw_in;
  assign rd_acc    = access & r_nw_in;
  assign pal_range = (vram_a_in[13:8] == 6'h3F);
  assign nmi_out   = vblank_q & nmi_en_q;

  // NOTE: async reset clears every register here; non-blocking (<=) keeps all state updates
  // sampling the pre-edge values, so cross-register ordering inside this block is irrelevant.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= IDLE;
      q_ncs            <= 1'b1;
      toggle_q         <= 1'b0;
      vblank_q         <= 1'b0;
      nmi_en_q         <= 1'b0;
      rnw_q            <= 1'b0;
      rd_buf_q         <= 8'h00;
      cpu_d_out        <= 8'h00;
      vram_d_out       <= 8'h00;
      fv_out           <= 3'd0;
      vt_out           <= 5'd0;
      v_out            <= 1'b0;
      fh_out           <= 3'd0;
      ht_out           <= 5'd0;
      h_out            <= 1'b0;
      s_out            <= 1'b0;
      spr_pt_sel_out   <= 1'b0;
      spr_h_out        <= 1'b0;
      inc_addr_amt_out <= 1'b0;
      upd_cntrs_out    <= 1'b0;
      bg_en_out        <= 1'b0;
      spr_en_out       <= 1'b0;
      bg_ls_clip_out   <= 1'b0;
      spr_ls_clip_out  <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_ncs         <= ncs_in;
      upd_cntrs_out <= 1'b0;

      if (wr_acc) begin
        case (sel_in)
          3'd0: begin
            {v_out, h_out}   <= cpu_d_in[1:0];
            inc_addr_amt_out <= cpu_d_in[2];
            spr_pt_sel_out   <= cpu_d_in[3];
            s_out            <= cpu_d_in[4];
            spr_h_out        <= cpu_d_in[5];
            nmi_en_q         <= cpu_d_in[7];
          end
          3'd1: begin
            bg_ls_clip_out  <= cpu_d_in[1];
            spr_ls_clip_out <= cpu_d_in[2];
            bg_en_out       <= cpu_d_in[3];
            spr_en_out      <= cpu_d_in[4];
          end
          3'd5: begin
            if (!toggle_q) begin
              fh_out <= cpu_d_in[2:0];
              ht_out <= cpu_d_in[7:3];
            end else begin
              fv_out <= cpu_d_in[2:0];
              vt_out <= cpu_d_in[7:3];
            end
            toggle_q <= ~toggle_q;
          end
          3'd6: begin
            if (!toggle_q) begin
              fv_out      <= {1'b0, cpu_d_in[5:4]};
              v_out       <= cpu_d_in[3];
              h_out       <= cpu_d_in[2];
              vt_out[4:3] <= cpu_d_in[1:0];
            end else begin
              vt_out[2:0]   <= cpu_d_in[7:5];
              ht_out        <= cpu_d_in[4:0];
              upd_cntrs_out <= 1'b1;
            end
            toggle_q <= ~toggle_q;
          end
          3'd7: begin
            rnw_q      <= 1'b0;
            vram_d_out <= cpu_d_in;
          end
          default: ;
        endcase
      end

      if (rd_acc) begin
        case (sel_in)
          3'd2: begin
            // A vblank pulse coinciding with the read is reported, then lost with the clear.
            cpu_d_out <= {vblank_q | vblank_set_in, spr_0_hit_in, spr_overflow_in, 5'b0};
            toggle_q  <= 1'b0;
          end
          3'd7:    rnw_q <= 1'b1;
          default: cpu_d_out <= rd_buf_q;
        endcase
      end

      if (state_q == XFER && rnw_q) begin
        cpu_d_out <= pal_range ? {2'b00, pram_d_in} : rd_buf_q;
        rd_buf_q  <= vram_d_in;
      end

      if (rd_acc && sel_in == 3'd2) vblank_q <= 1'b0;
      else if (vblank_set_in)       vblank_q <= 1'b1;
      else if (vblank_clr_in)       vblank_q <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    vram_wr_out  = 1'b0;
    pram_wr_out  = 1'b0;
    inc_addr_out = 1'b0;
    case (state_q)
      IDLE: if (access && sel_in == 3'd7) state_d = XFER;
      XFER: begin
        vram_wr_out = ~rnw_q & ~pal_range;
        pram_wr_out = ~rnw_q & pal_range;
        state_d     = INC;
      end
      INC: begin
        inc_addr_out = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppu_ri.sv
// Bench for ppu_ri: a loopy-style t/x register model plus byte-level control/mask/status
// state, compared against the DUT on every falling clock edge, plus pinned literal values.
module tb_ppu_ri;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [2:0] sel_in = 3'd0;
  logic       ncs_in = 1'b1;
  logic       r_nw_in = 1'b1;
  logic [7:0] cpu_d_in = 8'h00;
  logic [7:0] cpu_d_out;
  logic [13:0] vram_a_in = 14'h0000;
  logic [7:0] vram_d_in = 8'h00;
  logic [5:0] pram_d_in = 6'h00;
  logic [7:0] vram_d_out;
  logic       vram_wr_out, pram_wr_out;
  logic       vblank_set_in = 1'b0, vblank_clr_in = 1'b0;
  logic       spr_0_hit_in = 1'b0, spr_overflow_in = 1'b0;
  logic [2:0] fv_out, fh_out;
  logic [4:0] vt_out, ht_out;
  logic       v_out, h_out, s_out, spr_pt_sel_out, spr_h_out;
  logic       inc_addr_out, inc_addr_amt_out, upd_cntrs_out;
  logic       bg_en_out, spr_en_out, bg_ls_clip_out, spr_ls_clip_out, nmi_out;

  ppu_ri dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sel_in(sel_in), .ncs_in(ncs_in),
    .r_nw_in(r_nw_in), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .vram_a_in(vram_a_in), .vram_d_in(vram_d_in), .pram_d_in(pram_d_in),
    .vram_d_out(vram_d_out), .vram_wr_out(vram_wr_out), .pram_wr_out(pram_wr_out),
    .vblank_set_in(vblank_set_in), .vblank_clr_in(vblank_clr_in),
    .spr_0_hit_in(spr_0_hit_in), .spr_overflow_in(spr_overflow_in),
    .fv_out(fv_out), .vt_out(vt_out), .v_out(v_out), .fh_out(fh_out), .ht_out(ht_out),
    .h_out(h_out), .s_out(s_out), .spr_pt_sel_out(spr_pt_sel_out), .spr_h_out(spr_h_out),
    .inc_addr_out(inc_addr_out), .inc_addr_amt_out(inc_addr_amt_out),
    .upd_cntrs_out(upd_cntrs_out), .bg_en_out(bg_en_out), .spr_en_out(spr_en_out),
    .bg_ls_clip_out(bg_ls_clip_out), .spr_ls_clip_out(spr_ls_clip_out), .nmi_out(nmi_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: t = {fine_y[2:0], nt[1:0], coarse_y[4:0], coarse_x[4:0]}, x = fine x.
  logic [14:0] m_t;
  logic [2:0]  m_x;
  logic [7:0]  m_ctrl, m_mask, m_cpu_d, m_buf, m_vd;
  logic        m_w, m_vbl, m_vwr, m_pwr, m_inc, m_upd;
  logic        cmp_en = 1'b1;

  task automatic model_reset();
    m_t = '0; m_x = '0; m_ctrl = '0; m_mask = '0; m_cpu_d = '0; m_buf = '0; m_vd = '0;
    m_w = 0; m_vbl = 0; m_vwr = 0; m_pwr = 0; m_inc = 0; m_upd = 0;
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("scroll_t", {1'b0, fv_out, v_out, h_out, vt_out, ht_out}, {1'b0, m_t});
      check("fine_x", fh_out, m_x);
      check("ctrl", {spr_h_out, s_out, spr_pt_sel_out, inc_addr_amt_out}, m_ctrl[5:2]);
      check("mask", {spr_en_out, bg_en_out, spr_ls_clip_out, bg_ls_clip_out}, m_mask[4:1]);
      check("nmi", nmi_out, m_vbl & m_ctrl[7]);
      check("cpu_d", cpu_d_out, m_cpu_d);
      check("vram_d", vram_d_out, m_vd);
      check("strobes", {vram_wr_out, pram_wr_out, inc_addr_out, upd_cntrs_out},
            {m_vwr, m_pwr, m_inc, m_upd});
    end
  end

  // One CPU access; ncs_in stays low for 'hold' cycles. 'set_same' raises vblank_set_in
  // in the access cycle itself.
  task automatic cpu_access(input logic [2:0] sel, input logic rnw, input logic [7:0] d,
                            input int hold = 1, input logic set_same = 1'b0);
    logic pal;
    @(posedge clk_in); #2;
    sel_in = sel; r_nw_in = rnw; cpu_d_in = d; ncs_in = 1'b0; vblank_set_in = set_same;
    @(posedge clk_in); #1;
    vblank_set_in = 1'b0;
    if (!rnw) begin
      case (sel)
        3'd0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
        3'd1: m_mask = d;
        3'd5: begin
          if (!m_w) begin m_x = d[2:0]; m_t[4:0] = d[7:3]; end
          else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; end
          m_w = ~m_w;
        end
        3'd6: begin
          if (!m_w) m_t[14:8] = {1'b0, d[5:0]};
          else begin m_t[7:0] = d; m_upd = 1'b1; end
          m_w = ~m_w;
        end
        3'd7: m_vd = d;
        default: ;
      endcase
    end else begin
      case (sel)
        3'd2: begin
          m_cpu_d = {m_vbl | set_same, spr_0_hit_in, spr_overflow_in, 5'b0};
          m_vbl = 1'b0; m_w = 1'b0;
        end
        3'd7: ;
        default: m_cpu_d = m_buf;
      endcase
    end
    for (int i = 1; i < hold; i++) begin
      @(posedge clk_in); #1;
      m_upd = 1'b0;
    end
    ncs_in = 1'b1;
    if (sel == 3'd7) begin
      pal = (vram_a_in >= 14'h3F00);
      m_vwr = ~rnw & ~pal;
      m_pwr = ~rnw & pal;
      @(posedge clk_in); #1;
      m_vwr = 1'b0; m_pwr = 1'b0; m_inc = 1'b1;
      if (rnw) begin
        m_cpu_d = pal ? {2'b00, pram_d_in} : m_buf;
        m_buf = vram_d_in;
      end
      @(posedge clk_in); #1;
      m_inc = 1'b0;
    end else begin
      @(posedge clk_in); #1;
      m_upd = 1'b0;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic vbl_pulse(input logic set, input logic clr);
    @(posedge clk_in); #2;
    vblank_set_in = set; vblank_clr_in = clr;
    @(posedge clk_in); #1;
    if (set) m_vbl = 1'b1;
    else if (clr) m_vbl = 1'b0;
    vblank_set_in = 1'b0; vblank_clr_in = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_cpu_d", cpu_d_out, 8'h00);
    check("reset_nmi", nmi_out, 1'b0);
    @(posedge clk_in); #2;
    rst_n_in = 1'b1;

    // $2006 pair
    cpu_access(3'd6, 1'b0, 8'h21);
    cpu_access(3'd6, 1'b0, 8'h08);
    check("p2006_fv", fv_out, 3'd2);
    check("p2006_vh", {v_out, h_out}, 2'b00);
    check("p2006_vt", vt_out, 5'h08);
    check("p2006_ht", ht_out, 5'h08);

    // $2005 pair, first write with chip select held low for several cycles
    cpu_access(3'd5, 1'b0, 8'h7D, 4);
    cpu_access(3'd5, 1'b0, 8'h5E);
    check("p2005_fh", fh_out, 3'd5);
    check("p2005_ht", ht_out, 5'd15);
    check("p2005_fv", fv_out, 3'd6);
    check("p2005_vt", vt_out, 5'd11);

    // $2002 read between the pair resets the toggle
    cpu_access(3'd5, 1'b0, 8'h7D);
    cpu_access(3'd2, 1'b1, 8'h00);
    cpu_access(3'd5, 1'b0, 8'h13);
    check("toggle_reset_fh", fh_out, 3'd3);
    check("toggle_reset_ht", ht_out, 5'd2);

    cpu_access(3'd1, 1'b0, 8'h1E);
    cpu_access(3'd0, 1'b0, 8'h3F);
    cpu_access(3'd0, 1'b0, 8'h00);

    // vblank / NMI
    vbl_pulse(1'b1, 1'b0);
    cpu_access(3'd0, 1'b0, 8'h80);
    check("nmi_on", nmi_out, 1'b1);
    spr_0_hit_in = 1'b1; spr_overflow_in = 1'b1;
    cpu_access(3'd2, 1'b1, 8'h00);
    check("status_read", cpu_d_out, 8'hE0);
    check("nmi_off", nmi_out, 1'b0);
    spr_0_hit_in = 1'b0; spr_overflow_in = 1'b0;
    vbl_pulse(1'b1, 1'b1);
    vbl_pulse(1'b0, 1'b1);
    cpu_access(3'd2, 1'b1, 8'h00, 1, 1'b1);
    check("set_same_read", cpu_d_out, 8'h80);
    check("set_same_flag", nmi_out, 1'b0);

    // $2007 buffered reads
    vram_a_in = 14'h2000; vram_d_in = 8'h11;
    cpu_access(3'd7, 1'b1, 8'h00);
    vram_d_in = 8'h22;
    cpu_access(3'd7, 1'b1, 8'h00);
    check("buf_read", cpu_d_out, 8'h11);
    cpu_access(3'd5, 1'b1, 8'h00);
    check("wo_read_buf", cpu_d_out, 8'h22);

    // palette range
    vram_a_in = 14'h3F01; pram_d_in = 6'h2A; vram_d_in = 8'h33;
    cpu_access(3'd7, 1'b1, 8'h00);
    check("pal_read", cpu_d_out, 8'h2A);
    cpu_access(3'd7, 1'b0, 8'h15);
    vram_a_in = 14'h2005;
    cpu_access(3'd7, 1'b0, 8'hA7);
    cpu_access(3'd0, 1'b0, 8'h04);
    cpu_access(3'd7, 1'b1, 8'h00);

    // Reset in the middle of a $2007 write transfer
    cpu_access(3'd6, 1'b0, 8'h3F);
    @(posedge clk_in); #2;
    sel_in = 3'd7; r_nw_in = 1'b0; cpu_d_in = 8'h5A; ncs_in = 1'b0;
    @(posedge clk_in); #1;
    m_vd = 8'h5A; m_vwr = 1'b1;
    ncs_in = 1'b1;
    #1 rst_n_in = 1'b0;
    model_reset();
    @(negedge clk_in); #1;
    check("rst_mid_vwr", {vram_wr_out, pram_wr_out, inc_addr_out}, 3'b000);
    check("rst_mid_fv", fv_out, 3'd0);
    check("rst_mid_vd", vram_d_out, 8'h00);
    @(posedge clk_in); #2;
    rst_n_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("post_rst_inc", inc_addr_out, 1'b0);
    cpu_access(3'd5, 1'b0, 8'hFF);
    check("post_rst_first", fh_out, 3'd7);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
